gray_step_ctrl: RTL and testbench
=================================

Name: gray_step_ctrl

Overview:
- Command-driven sequencer that walks a W-bit Gray-code position register a requested number of steps, up or down.
- Provides a start/busy/done handshake, a hold (pause) input and an abort input.
- Sits between a control FSM and any logic consuming a single-bit-change position code, such as encoder emulation or a phase selector.
- Replaces the free-running Gray counter wherever stepping must be bounded and commanded.

Parameters:
- W, 3: Gray position width; the position wraps modulo 2^W.
- CNT_W, 8: width of the step-count command.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  reset; synchronous, active-low.
- START  in  1  command strobe; sampled only in IDLE.
- DIR  in  1  1 = up, 0 = down; sampled with START.
- STEPS  in  CNT_W  number of steps to perform; sampled with START.
- HOLD  in  1  1 = freeze stepping while in RUN.
- ABORT  in  1  1 = terminate the command.
- CLR  in  1  1 in IDLE = zero the position.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-cycle pulse on normal completion.
- STEP  out  1  one-cycle pulse in each cycle Y shows a new value.
- WRAP  out  1  one-cycle pulse coincident with a STEP that crossed the modulo boundary.
- Y  out  W  Gray-coded position; Y = bin ^ (bin >> 1).

Behaviour:
- Internal registers: state {IDLE, RUN, FIN}, bin[W], rem[CNT_W], dir_q.
- Outputs: BUSY = (state == RUN); DONE = (state == FIN). STEP and WRAP are registered. Y is derived only from registered bin, so it is glitch-free relative to CLK.
- Reset (RESET_N = 0 at a rising edge): state = IDLE, bin = 0, rem = 0, dir_q = 0. After that edge: Y = 0, BUSY = 0, DONE = 0, STEP = 0, WRAP = 0. Reset applies mid-run as well; no DONE is produced.
- Input priority at every edge: RESET_N > ABORT > START/CLR > HOLD.
- IDLE:
  - ABORT = 1: stay in IDLE; START is ignored.
  - Else START = 1 and STEPS != 0: dir_q = DIR, rem = STEPS, go to RUN.
  - Else START = 1 and STEPS == 0: go to FIN; no step occurs.
  - Else CLR = 1: bin = 0, stay in IDLE.
  - START and CLR together: START wins; CLR is ignored.
- RUN:
  - ABORT = 1: go to IDLE; bin keeps its value, rem = 0, no DONE, STEP = 0.
  - Else HOLD = 1: no change; STEP = 0 next cycle.
  - Else:
    - bin = bin + 1 (dir_q = 1) or bin - 1 (dir_q = 0), both modulo 2^W; rem = rem - 1.
    - STEP = 1 next cycle.
    - WRAP = 1 next cycle if bin went from 2^W-1 to 0 (up) or from 0 to 2^W-1 (down).
    - If rem was 1, go to FIN.
  - START, CLR, DIR and STEPS are ignored in RUN.
- FIN: lasts one cycle, then returns to IDLE unconditionally. START is ignored; ABORT has no effect.
- Latency:
  - START accepted at edge k: BUSY = 1 from cycle k+1.
  - With no HOLD, steps occur at edges k+1 .. k+N, and BUSY = 1 for exactly N cycles.
  - DONE = 1 in the cycle after edge k+N.
  - The earliest new START is accepted at edge k+N+2.
  - Each cycle with HOLD = 1 in RUN adds one cycle to BUSY and delays DONE by one cycle.
- Invariants:
  - Y changes only in cycles where STEP = 1, and each change flips exactly one bit.
  - The number of STEP pulses equals STEPS unless ABORT or reset occurs.
  - STEPS = 2^W returns Y to its start value with exactly one WRAP.
- Arithmetic: rem must never underflow; with STEPS = 2^CNT_W - 1, all steps are performed.

Test Plan:
1. Reset, then START with STEPS=8, DIR=1, W=3 → Y on consecutive cycles = 001,011,010,110,111,101,100,000; WRAP only with 000; BUSY high for 8 cycles; DONE one cycle later; exactly 8 STEP pulses.
2. From Y=000, START with STEPS=3, DIR=0 → Y = 100,101,111; WRAP with the first step only; DONE follows.
3. STEPS=5, DIR=1, HOLD=1 for 2 cycles after the second step → Y holds at 011 with STEP=0 during the hold; BUSY high for 7 cycles; final Y=111.
4. START with STEPS=0 → BUSY never asserts; DONE pulses in the cycle after START; Y unchanged; no STEP.
5. STEPS=6; ABORT after 2 steps; START pulsed while BUSY → BUSY drops after the ABORT edge; Y stays 011; no DONE; the mid-run START has no effect. Then CLR in IDLE → Y=000.
6. RESET_N low for one edge mid-run (Y=010) → next cycle Y=000, BUSY=0, DONE=0, STEP=0; a subsequent START with STEPS=1 gives Y=001.

Source files
------------

// File: rtl/gray_step_ctrl.sv
// gray_step_ctrl
//   Command-driven Gray-code stepper. On an accepted START it walks a W-bit
//   position a commanded number of steps up or down, one step per cycle,
//   pausing while HOLD is high and terminating early on ABORT.
//
// Ports
//   CLK      clock, all state updates on the rising edge
//   RESET_N  synchronous active-low reset
//   START    command strobe, sampled only in IDLE
//   DIR      1 = up, 0 = down, sampled with START
//   STEPS    number of steps to perform, sampled with START
//   HOLD     freeze stepping while running
//   ABORT    terminate the command (back to IDLE, no DONE)
//   CLR      zero the position while idle
//   BUSY     high while running
//   DONE     one-cycle pulse on normal completion
//   STEP     one-cycle pulse in each cycle Y shows a new value
//   WRAP     one-cycle pulse with a STEP that crossed the modulo boundary
//   Y        Gray-coded position, bin ^ (bin >> 1)
module gray_step_ctrl #(
    parameter int unsigned W     = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             DIR,
    input  logic [CNT_W-1:0] STEPS,
    input  logic             HOLD,
    input  logic             ABORT,
    input  logic             CLR,
    output logic             BUSY,
    output logic             DONE,
    output logic             STEP,
    output logic             WRAP,
    output logic [W-1:0]     Y
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     bin_q, bin_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ABORT) begin
                    // Abort in IDLE swallows any coincident START.
                    state_d = IDLE;
                end else if (START) begin
                    if (STEPS != '0) begin
                        dir_d   = DIR;
                        rem_d   = STEPS;
                        state_d = RUN;
                    end else begin
                        // Zero-length command completes immediately.
                        state_d = FIN;
                    end
                end else if (CLR) begin
                    bin_d = '0;
                end
            end
            RUN: begin
                if (ABORT) begin
                    rem_d   = '0;
                    state_d = IDLE;
                end else if (!HOLD) begin
                    if (dir_q) begin
                        bin_d  = bin_q + W'(1);
                        wrap_d = (bin_q == {W{1'b1}});
                    end else begin
                        bin_d  = bin_q - W'(1);
                        wrap_d = (bin_q == '0);
                    end
                    step_d = 1'b1;
                    // rem is never zero in RUN, so this cannot underflow.
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            bin_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);
    assign STEP = step_q;
    assign WRAP = wrap_q;
    // Built only from registered bin, so Y never glitches within a cycle.
    assign Y    = bin_q ^ (bin_q >> 1);

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Bench for gray_step_ctrl: directed scenarios with literal expectations plus
// randomized stimulus, all compared every cycle against an integer position model.
module tb_gray_step_ctrl;

    localparam int W     = 3;
    localparam int CNT_W = 8;
    localparam int MOD   = 1 << W;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic             START;
    logic             DIR;
    logic [CNT_W-1:0] STEPS;
    logic             HOLD;
    logic             ABORT;
    logic             CLR;
    logic             BUSY;
    logic             DONE;
    logic             STEP;
    logic             WRAP;
    logic [W-1:0]     Y;

    int checks = 0;
    int errors = 0;

    // Model: position as a plain integer, mode 0 idle / 1 running / 2 finishing.
    int m_mode  = 0;
    int m_pos   = 0;
    int m_rem   = 0;
    bit m_dir   = 1'b0;
    bit m_step  = 1'b0;
    bit m_wrap  = 1'b0;
    bit m_valid = 1'b0;
    bit m_jump  = 1'b0;
    int prev_y  = 0;

    gray_step_ctrl #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .DIR     (DIR),
        .STEPS   (STEPS),
        .HOLD    (HOLD),
        .ABORT   (ABORT),
        .CLR     (CLR),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .STEP    (STEP),
        .WRAP    (WRAP),
        .Y       (Y)
    );

    always #5 CLK = ~CLK;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Reference model, advanced on each rising edge from the stable inputs.
    initial begin
        int np;
        forever begin
            @(posedge CLK);
            m_step = 1'b0;
            m_wrap = 1'b0;
            m_jump = 1'b0;
            if (!RESET_N) begin
                m_mode  = 0;
                m_pos   = 0;
                m_rem   = 0;
                m_dir   = 1'b0;
                m_valid = 1'b1;
                m_jump  = 1'b1;
            end else if (m_mode == 0) begin
                if (!ABORT && START) begin
                    if (int'(STEPS) == 0) begin
                        m_mode = 2;
                    end else begin
                        m_mode = 1;
                        m_rem  = int'(STEPS);
                        m_dir  = DIR;
                    end
                end else if (!ABORT && CLR) begin
                    m_jump = (m_pos != 0);
                    m_pos  = 0;
                end
            end else if (m_mode == 1) begin
                if (ABORT) begin
                    m_mode = 0;
                    m_rem  = 0;
                end else if (!HOLD) begin
                    np     = m_dir ? m_pos + 1 : m_pos - 1;
                    m_wrap = (np < 0) || (np >= MOD);
                    m_pos  = (np + MOD) % MOD;
                    m_step = 1'b1;
                    m_rem  = m_rem - 1;
                    if (m_rem == 0) m_mode = 2;
                end
            end else begin
                m_mode = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                chk("cmp_y", int'(Y), gray(m_pos));
                chk("cmp_busy", int'(BUSY), int'(m_mode == 1));
                chk("cmp_done", int'(DONE), int'(m_mode == 2));
                chk("cmp_step", int'(STEP), int'(m_step));
                chk("cmp_wrap", int'(WRAP), int'(m_wrap));
                if ((int'(Y) != prev_y) && !m_jump) begin
                    chk("inv_single_bit_step",
                        int'(STEP && ($countones(Y ^ W'(prev_y)) == 1)), 1);
                end
                prev_y = int'(Y);
            end
        end
    end

    initial begin
        logic [W-1:0] seq1 [8];
        int sc;
        int wc;
        int bc;
        int cyc;
        seq1[0] = 3'b001; seq1[1] = 3'b011; seq1[2] = 3'b010; seq1[3] = 3'b110;
        seq1[4] = 3'b111; seq1[5] = 3'b101; seq1[6] = 3'b100; seq1[7] = 3'b000;

        RESET_N = 1'b0; START = 1'b0; DIR = 1'b0; STEPS = '0;
        HOLD = 1'b0; ABORT = 1'b0; CLR = 1'b0;
        tick();
        tick();
        chk("rst_y", int'(Y), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_step", int'(STEP), 0);
        RESET_N = 1'b1;
        tick();

        // 1: eight steps up, full wrap.
        START = 1'b1; STEPS = 8'd8; DIR = 1'b1;
        tick();
        START = 1'b0;
        chk("t1_busy_start", int'(BUSY), 1);
        chk("t1_y_start", int'(Y), 0);
        sc = 0; wc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_y", int'(Y), int'(seq1[i]));
            sc += int'(STEP);
            wc += int'(WRAP);
            chk("t1_busy", int'(BUSY), int'(i < 7));
        end
        chk("t1_done", int'(DONE), 1);
        chk("t1_steps", sc, 8);
        chk("t1_wraps", wc, 1);
        chk("t1_last_wrap", int'(WRAP), 1);
        tick();
        chk("t1_done_clear", int'(DONE), 0);

        // 2: three steps down from 000.
        START = 1'b1; STEPS = 8'd3; DIR = 1'b0;
        tick();
        START = 1'b0;
        tick();
        chk("t2_y0", int'(Y), 3'b100);
        chk("t2_wrap0", int'(WRAP), 1);
        tick();
        chk("t2_y1", int'(Y), 3'b101);
        chk("t2_wrap1", int'(WRAP), 0);
        tick();
        chk("t2_y2", int'(Y), 3'b111);
        chk("t2_done", int'(DONE), 1);
        tick();

        // 3: five steps up with a two-cycle hold after the second step.
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        START = 1'b1; STEPS = 8'd5; DIR = 1'b1;
        tick();
        START = 1'b0;
        bc = int'(BUSY);
        tick(); bc += int'(BUSY);
        tick(); bc += int'(BUSY);
        HOLD = 1'b1;
        tick(); bc += int'(BUSY);
        chk("t3_hold_y", int'(Y), 3'b011);
        chk("t3_hold_step", int'(STEP), 0);
        tick(); bc += int'(BUSY);
        chk("t3_hold_y2", int'(Y), 3'b011);
        HOLD = 1'b0;
        cyc = 0;
        while (!DONE && cyc < 10) begin
            tick(); bc += int'(BUSY);
            cyc++;
        end
        chk("t3_done_seen", int'(DONE), 1);
        chk("t3_busy_cycles", bc, 7);
        chk("t3_y_final", int'(Y), 3'b111);
        tick();

        // 4: zero-length command.
        START = 1'b1; STEPS = 8'd0;
        tick();
        START = 1'b0;
        chk("t4_busy", int'(BUSY), 0);
        chk("t4_done", int'(DONE), 1);
        chk("t4_step", int'(STEP), 0);
        chk("t4_y", int'(Y), 3'b111);
        tick();
        chk("t4_done_clear", int'(DONE), 0);

        // 5: abort after two steps, with a START during RUN, then CLR.
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        START = 1'b1; STEPS = 8'd6; DIR = 1'b1;
        tick();
        START = 1'b0;
        tick();
        START = 1'b1; STEPS = 8'd2; DIR = 1'b0;
        tick();
        START = 1'b0;
        chk("t5_y_mid", int'(Y), 3'b011);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("t5_busy", int'(BUSY), 0);
        chk("t5_done", int'(DONE), 0);
        chk("t5_y", int'(Y), 3'b011);
        tick();
        chk("t5_y_idle", int'(Y), 3'b011);
        chk("t5_done_idle", int'(DONE), 0);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("t5_clr", int'(Y), 0);

        // 6: reset mid-run, then a single step.
        START = 1'b1; STEPS = 8'd5; DIR = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        chk("t6_y_pre", int'(Y), 3'b010);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        chk("t6_y", int'(Y), 0);
        chk("t6_busy", int'(BUSY), 0);
        chk("t6_done", int'(DONE), 0);
        chk("t6_step", int'(STEP), 0);
        START = 1'b1; STEPS = 8'd1; DIR = 1'b1;
        tick();
        START = 1'b0;
        tick();
        chk("t6_y1", int'(Y), 3'b001);
        chk("t6_done1", int'(DONE), 1);
        tick();

        // 7: maximum step count is fully performed.
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        START = 1'b1; STEPS = 8'd255; DIR = 1'b1;
        tick();
        START = 1'b0;
        sc = 0; cyc = 0;
        while (!DONE && cyc < 400) begin
            tick();
            sc += int'(STEP);
            cyc++;
        end
        chk("t7_done_seen", int'(DONE), 1);
        chk("t7_steps", sc, 255);
        chk("t7_y", int'(Y), 3'b100);
        tick();

        // Randomized phase, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            RESET_N = ($urandom_range(0, 199) != 0);
            START   = ($urandom_range(0, 3) == 0);
            DIR     = 1'($urandom_range(0, 1));
            STEPS   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 9));
            HOLD    = ($urandom_range(0, 4) == 0);
            ABORT   = ($urandom_range(0, 39) == 0);
            CLR     = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
